// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/bubble and forwarding control for a 5-stage MIPS pipeline.
// Tracks the destination register and remaining Tnew of the instructions in E, M
// and W. From those records it compares each D-stage operand's Tuse against the
// producer's Tnew. The result is a stall request plus the forwarding-mux selects
// for the D and E stages.
// Optional build macro: HAZARD_PERF_EN adds saturating 32-bit stall_cnt and
// fwd_cnt performance counters.
module hazard_ctrl #(
    parameter int ADDR_W = 5,
    parameter int T_W    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [T_W-1:0]    Tuse_rs,
    input  logic [T_W-1:0]    Tuse_rt,
    input  logic [T_W-1:0]    TnewD,
    input  logic [ADDR_W-1:0] A_rsD,
    input  logic [ADDR_W-1:0] A_rtD,
    input  logic [ADDR_W-1:0] AwriteD,
    output logic              stall,
    output logic [1:0]        FwdRsD,
    output logic [1:0]        FwdRtD,
    output logic [1:0]        FwdRsE,
    output logic [1:0]        FwdRtE,
`ifdef HAZARD_PERF_EN
    output logic [31:0]       stall_cnt,
    output logic [31:0]       fwd_cnt,
`endif
    output logic [ADDR_W-1:0] A_writeW
);

    // Forwarding-mux encodings shared by the D and E selects
    localparam logic [1:0] FWD_NONE = 2'd0;
    localparam logic [1:0] FWD_E    = 2'd1;
    localparam logic [1:0] FWD_M    = 2'd2;
    localparam logic [1:0] FWD_W    = 2'd3;

    // Saturating decrement: a produced result stays "ready" (Tnew = 0)
    function automatic logic [T_W-1:0] satdec(input logic [T_W-1:0] x);
        return (x == '0) ? '0 : x - 1'b1;
    endfunction

    // ------------------------------------------------------------------
    // Stage records
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] rs_e_reg, rs_e_next;
    logic [ADDR_W-1:0] rt_e_reg, rt_e_next;
    logic [ADDR_W-1:0] a_e_reg,  a_e_next;
    logic [T_W-1:0]    tnew_e_reg, tnew_e_next;
    logic [ADDR_W-1:0] a_m_reg,  a_m_next;
    logic [T_W-1:0]    tnew_m_reg, tnew_m_next;
    logic [ADDR_W-1:0] a_w_reg,  a_w_next;

    // Per-operand views: index 0 = rs, index 1 = rt
    logic [ADDR_W-1:0] a_d    [2];
    logic [T_W-1:0]    tuse_d [2];
    logic [ADDR_W-1:0] a_x_e  [2];
    logic [1:0]        fwd_d  [2];
    logic [1:0]        fwd_e  [2];
    logic [1:0]        haz_e;
    logic [1:0]        haz_m;

    assign a_d[0]    = A_rsD;
    assign a_d[1]    = A_rtD;
    assign tuse_d[0] = Tuse_rs;
    assign tuse_d[1] = Tuse_rt;
    assign a_x_e[0]  = rs_e_reg;
    assign a_x_e[1]  = rt_e_reg;

    // ------------------------------------------------------------------
    // Per-operand hazard detection and forwarding selection
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_operand
            logic match_e_d;
            logic match_m_d;
            logic match_w_d;
            logic match_m_e;
            logic match_w_e;

            // Address matches of the D-stage and E-stage operand against the records
            always_comb begin
                match_e_d = (a_d[gi] != '0) && (a_d[gi] == a_e_reg);
                match_m_d = (a_d[gi] != '0) && (a_d[gi] == a_m_reg);
                match_w_d = (a_d[gi] != '0) && (a_d[gi] == a_w_reg);
                match_m_e = (a_x_e[gi] != '0) && (a_x_e[gi] == a_m_reg);
                match_w_e = (a_x_e[gi] != '0) && (a_x_e[gi] == a_w_reg);
            end

            // A producer whose result arrives later than the operand is needed forces a stall
            always_comb begin
                haz_e[gi] = match_e_d && (tnew_e_reg > tuse_d[gi]);
                haz_m[gi] = match_m_d && (tnew_m_reg > tuse_d[gi]);
            end

            // D-stage select: youngest ready producer wins (E > M > W)
            always_comb begin
                fwd_d[gi] = FWD_NONE;
                if (match_e_d && (tnew_e_reg == '0)) begin
                    fwd_d[gi] = FWD_E;
                end else if (match_m_d && (tnew_m_reg == '0)) begin
                    fwd_d[gi] = FWD_M;
                end else if (match_w_d) begin
                    fwd_d[gi] = FWD_W;
                end
            end

            // E-stage select: M result preferred over W result
            always_comb begin
                fwd_e[gi] = FWD_NONE;
                if (match_m_e && (tnew_m_reg == '0)) begin
                    fwd_e[gi] = FWD_M;
                end else if (match_w_e) begin
                    fwd_e[gi] = FWD_W;
                end
            end
        end
    endgenerate

    assign stall    = (|haz_e) | (|haz_m);
    assign FwdRsD   = fwd_d[0];
    assign FwdRtD   = fwd_d[1];
    assign FwdRsE   = fwd_e[0];
    assign FwdRtE   = fwd_e[1];
    assign A_writeW = a_w_reg;

    // ------------------------------------------------------------------
    // Record advance
    // ------------------------------------------------------------------

    // Next-record computation: E bubbles on stall, M and W always advance
    always_comb begin
        rs_e_next   = A_rsD;
        rt_e_next   = A_rtD;
        a_e_next    = AwriteD;
        tnew_e_next = satdec(TnewD);
        if (stall) begin
            rs_e_next   = '0;
            rt_e_next   = '0;
            a_e_next    = '0;
            tnew_e_next = '0;
        end
        a_m_next    = a_e_reg;
        tnew_m_next = satdec(tnew_e_reg);
        a_w_next    = a_m_reg;
    end

    // Record registers; reset discards every in-flight record
    always_ff @(posedge clk) begin
        if (reset) begin
            rs_e_reg   <= '0;
            rt_e_reg   <= '0;
            a_e_reg    <= '0;
            tnew_e_reg <= '0;
            a_m_reg    <= '0;
            tnew_m_reg <= '0;
            a_w_reg    <= '0;
        end else begin
            rs_e_reg   <= rs_e_next;
            rt_e_reg   <= rt_e_next;
            a_e_reg    <= a_e_next;
            tnew_e_reg <= tnew_e_next;
            a_m_reg    <= a_m_next;
            tnew_m_reg <= tnew_m_next;
            a_w_reg    <= a_w_next;
        end
    end

`ifdef HAZARD_PERF_EN
    // ------------------------------------------------------------------
    // Performance counters (saturating)
    // ------------------------------------------------------------------
    logic [31:0] stall_cnt_reg, stall_cnt_next;
    logic [31:0] fwd_cnt_reg,   fwd_cnt_next;
    logic        any_fwd;

    assign any_fwd = (FwdRsD != FWD_NONE) || (FwdRtD != FWD_NONE) ||
                     (FwdRsE != FWD_NONE) || (FwdRtE != FWD_NONE);

    // Increment on the event, holding at all-ones
    always_comb begin
        stall_cnt_next = stall_cnt_reg;
        fwd_cnt_next   = fwd_cnt_reg;
        if (stall && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
            stall_cnt_next = stall_cnt_reg + 32'd1;
        end
        if (any_fwd && (fwd_cnt_reg != 32'hFFFF_FFFF)) begin
            fwd_cnt_next = fwd_cnt_reg + 32'd1;
        end
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_reg <= '0;
            fwd_cnt_reg   <= '0;
        end else begin
            stall_cnt_reg <= stall_cnt_next;
            fwd_cnt_reg   <= fwd_cnt_next;
        end
    end

    assign stall_cnt = stall_cnt_reg;
    assign fwd_cnt   = fwd_cnt_reg;
`endif

endmodule
